// File: rtl/axi_slave_connector_cut.sv
// Flat AXI4 slave port to struct-based fabric connector with optional
// per-channel register cuts, ATOP pass-through and outstanding limiting.

package axi_slave_connector_cut_pkg;
    localparam int unsigned PKG_DW = 64;
    localparam int unsigned PKG_AW = 64;
    localparam int unsigned PKG_IW = 4;
    localparam int unsigned PKG_UW = 1;

    typedef struct packed {
        logic [PKG_IW-1:0]   id;
        logic [PKG_AW-1:0]   addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                lock;
        logic [3:0]          cache;
        logic [2:0]          prot;
        logic [3:0]          qos;
        logic [3:0]          region;
        logic [5:0]          atop;
        logic [PKG_UW-1:0]   user;
    } aw_chan_t;

    typedef struct packed {
        logic [PKG_DW-1:0]   data;
        logic [PKG_DW/8-1:0] strb;
        logic                last;
        logic [PKG_UW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [PKG_IW-1:0]   id;
        logic [1:0]          resp;
        logic [PKG_UW-1:0]   user;
    } b_chan_t;

    typedef struct packed {
        logic [PKG_IW-1:0]   id;
        logic [PKG_AW-1:0]   addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                lock;
        logic [3:0]          cache;
        logic [2:0]          prot;
        logic [3:0]          qos;
        logic [3:0]          region;
        logic [PKG_UW-1:0]   user;
    } ar_chan_t;

    typedef struct packed {
        logic [PKG_IW-1:0]   id;
        logic [PKG_DW-1:0]   data;
        logic [1:0]          resp;
        logic                last;
        logic [PKG_UW-1:0]   user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } axi_rsp_t;
endpackage

// Two-entry skid buffer (EN=1) or plain wire (EN=0) for one channel.
// Input ready depends only on the occupancy register and reset, never on
// out_ready, so the cut fully breaks the ready path.
module axi_slave_cut_buf #(
    parameter int unsigned W  = 1,
    parameter bit          EN = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         empty
);
    if (EN) begin : g_cut
        logic [W-1:0] mem_q [2];
        logic         rd_ptr_q;
        logic         wr_ptr_q;
        logic [1:0]   occ_q;
        logic         push;
        logic         pop;

        assign in_ready  = (occ_q != 2'd2) & ~rst_i;
        assign out_valid = (occ_q != 2'd0);
        assign out_data  = mem_q[rd_ptr_q];
        assign empty     = (occ_q == 2'd0);
        assign push      = in_valid & in_ready;
        assign pop       = out_valid & out_ready;

        // Pointer and occupancy bookkeeping; push+pop leaves occupancy alone.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                occ_q    <= 2'd0;
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= ~wr_ptr_q;
                if (pop)  rd_ptr_q <= ~rd_ptr_q;
                if (push && !pop)      occ_q <= occ_q + 2'd1;
                else if (pop && !push) occ_q <= occ_q - 2'd1;
            end
        end

        // Payload storage; contents are don't-care while the slot is empty.
        always_ff @(posedge clk_i) begin
            if (push) mem_q[wr_ptr_q] <= in_data;
        end
    end else begin : g_wire
        assign in_ready  = out_ready & ~rst_i;
        assign out_valid = in_valid & ~rst_i;
        assign out_data  = in_data;
        assign empty     = 1'b1;
    end
endmodule

// Top-level connector.
// Handshake rule on every channel: a beat transfers on a rising clk_i edge
// where valid and ready are both high; a source never drops valid or
// changes payload before that edge, and ready never waits on valid.
module axi_slave_connector_cut #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned STRB_WIDTH   = DATA_WIDTH/8,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned USER_WIDTH   = 1,
    parameter bit          ATOP_EN      = 1'b0,
    parameter bit          CUT_AW       = 1'b1,
    parameter bit          CUT_W        = 1'b1,
    parameter bit          CUT_B        = 1'b1,
    parameter bit          CUT_AR       = 1'b1,
    parameter bit          CUT_R        = 1'b1,
    parameter int unsigned MAX_WR_OUTST = 8,
    parameter int unsigned MAX_RD_OUTST = 8,
    parameter type axi_req_t = axi_slave_connector_cut_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_slave_connector_cut_pkg::axi_rsp_t,
    localparam int unsigned WR_CW = $clog2(MAX_WR_OUTST+1),
    localparam int unsigned RD_CW = $clog2(MAX_RD_OUTST+1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic [3:0]            s_axi_awqos,
    input  logic [3:0]            s_axi_awregion,
    input  logic [USER_WIDTH-1:0] s_axi_awuser,
    input  logic [5:0]            s_axi_awatop,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic [USER_WIDTH-1:0] s_axi_wuser,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic [USER_WIDTH-1:0] s_axi_buser,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic [3:0]            s_axi_arqos,
    input  logic [3:0]            s_axi_arregion,
    input  logic [USER_WIDTH-1:0] s_axi_aruser,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic [USER_WIDTH-1:0] s_axi_ruser,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output axi_req_t              axi_req_o,
    input  axi_rsp_t              axi_resp_i,
    output logic [WR_CW-1:0]      wr_outst_o,
    output logic [RD_CW-1:0]      rd_outst_o,
    output logic                  idle_o
);
    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [USER_WIDTH-1:0] user;
    } aw_beat_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [USER_WIDTH-1:0] user;
    } ar_beat_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } w_beat_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [1:0]            resp;
        logic [USER_WIDTH-1:0] user;
    } b_beat_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } r_beat_t;

    localparam int unsigned      RD_SW  = RD_CW + 1;
    localparam logic [WR_CW-1:0] WR_MAX = WR_CW'(MAX_WR_OUTST);
    localparam logic [RD_CW-1:0] RD_MAX = RD_CW'(MAX_RD_OUTST);

    aw_beat_t aw_in, aw_out;
    ar_beat_t ar_in, ar_out;
    w_beat_t  w_in,  w_out;
    b_beat_t  b_in,  b_out;
    r_beat_t  r_in,  r_out;

    logic aw_buf_ready, ar_buf_ready, w_buf_ready, b_buf_ready, r_buf_ready;
    logic aw_out_valid, ar_out_valid, w_out_valid;
    logic aw_empty, ar_empty, w_empty, b_empty, r_empty;
    logic [WR_CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [RD_CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [RD_SW-1:0] rd_sum;
    logic wr_full, rd_full;
    logic aw_hs, b_hs, ar_hs, r_last_hs, atop_rd;

    // Slave-side request payloads; atop only passes through when enabled.
    always_comb begin
        aw_in = '{id: s_axi_awid, addr: s_axi_awaddr, len: s_axi_awlen,
                  size: s_axi_awsize, burst: s_axi_awburst, lock: s_axi_awlock,
                  cache: s_axi_awcache, prot: s_axi_awprot, qos: s_axi_awqos,
                  region: s_axi_awregion, atop: (ATOP_EN ? s_axi_awatop : 6'd0),
                  user: s_axi_awuser};
        ar_in = '{id: s_axi_arid, addr: s_axi_araddr, len: s_axi_arlen,
                  size: s_axi_arsize, burst: s_axi_arburst, lock: s_axi_arlock,
                  cache: s_axi_arcache, prot: s_axi_arprot, qos: s_axi_arqos,
                  region: s_axi_arregion, user: s_axi_aruser};
        w_in  = '{data: s_axi_wdata, strb: s_axi_wstrb, last: s_axi_wlast,
                  user: s_axi_wuser};
        b_in  = '{id: axi_resp_i.b.id, resp: axi_resp_i.b.resp,
                  user: axi_resp_i.b.user};
        r_in  = '{id: axi_resp_i.r.id, data: axi_resp_i.r.data,
                  resp: axi_resp_i.r.resp, last: axi_resp_i.r.last,
                  user: axi_resp_i.r.user};
    end

    // Limits come from the counter registers only, so a same-cycle
    // completion reopens ready one cycle later.
    assign wr_full       = (wr_cnt_q == WR_MAX);
    assign rd_full       = (rd_cnt_q == RD_MAX);
    assign s_axi_awready = aw_buf_ready & ~wr_full;
    assign s_axi_arready = ar_buf_ready & ~rd_full;

    axi_slave_cut_buf #(.W($bits(aw_beat_t)), .EN(CUT_AW)) u_aw (
        .clk_i, .rst_i,
        .in_valid (s_axi_awvalid & ~wr_full), .in_ready (aw_buf_ready), .in_data (aw_in),
        .out_valid(aw_out_valid), .out_ready(axi_resp_i.aw_ready), .out_data(aw_out),
        .empty    (aw_empty));

    axi_slave_cut_buf #(.W($bits(w_beat_t)), .EN(CUT_W)) u_w (
        .clk_i, .rst_i,
        .in_valid (s_axi_wvalid), .in_ready (w_buf_ready), .in_data (w_in),
        .out_valid(w_out_valid), .out_ready(axi_resp_i.w_ready), .out_data(w_out),
        .empty    (w_empty));

    axi_slave_cut_buf #(.W($bits(ar_beat_t)), .EN(CUT_AR)) u_ar (
        .clk_i, .rst_i,
        .in_valid (s_axi_arvalid & ~rd_full), .in_ready (ar_buf_ready), .in_data (ar_in),
        .out_valid(ar_out_valid), .out_ready(axi_resp_i.ar_ready), .out_data(ar_out),
        .empty    (ar_empty));

    axi_slave_cut_buf #(.W($bits(b_beat_t)), .EN(CUT_B)) u_b (
        .clk_i, .rst_i,
        .in_valid (axi_resp_i.b_valid), .in_ready (b_buf_ready), .in_data (b_in),
        .out_valid(s_axi_bvalid), .out_ready(s_axi_bready), .out_data(b_out),
        .empty    (b_empty));

    axi_slave_cut_buf #(.W($bits(r_beat_t)), .EN(CUT_R)) u_r (
        .clk_i, .rst_i,
        .in_valid (axi_resp_i.r_valid), .in_ready (r_buf_ready), .in_data (r_in),
        .out_valid(s_axi_rvalid), .out_ready(s_axi_rready), .out_data(r_out),
        .empty    (r_empty));

    assign s_axi_wready = w_buf_ready;
    assign s_axi_bid    = b_out.id;
    assign s_axi_bresp  = b_out.resp;
    assign s_axi_buser  = b_out.user;
    assign s_axi_rid    = r_out.id;
    assign s_axi_rdata  = r_out.data;
    assign s_axi_rresp  = r_out.resp;
    assign s_axi_rlast  = r_out.last;
    assign s_axi_ruser  = r_out.user;

    // Fabric request: fields not carried by this connector stay zero.
    always_comb begin
        axi_req_o           = '0;
        axi_req_o.aw.id     = aw_out.id;
        axi_req_o.aw.addr   = aw_out.addr;
        axi_req_o.aw.len    = aw_out.len;
        axi_req_o.aw.size   = aw_out.size;
        axi_req_o.aw.burst  = aw_out.burst;
        axi_req_o.aw.lock   = aw_out.lock;
        axi_req_o.aw.cache  = aw_out.cache;
        axi_req_o.aw.prot   = aw_out.prot;
        axi_req_o.aw.qos    = aw_out.qos;
        axi_req_o.aw.region = aw_out.region;
        axi_req_o.aw.atop   = aw_out.atop;
        axi_req_o.aw.user   = aw_out.user;
        axi_req_o.aw_valid  = aw_out_valid;
        axi_req_o.w.data    = w_out.data;
        axi_req_o.w.strb    = w_out.strb;
        axi_req_o.w.last    = w_out.last;
        axi_req_o.w.user    = w_out.user;
        axi_req_o.w_valid   = w_out_valid;
        axi_req_o.b_ready   = b_buf_ready;
        axi_req_o.ar.id     = ar_out.id;
        axi_req_o.ar.addr   = ar_out.addr;
        axi_req_o.ar.len    = ar_out.len;
        axi_req_o.ar.size   = ar_out.size;
        axi_req_o.ar.burst  = ar_out.burst;
        axi_req_o.ar.lock   = ar_out.lock;
        axi_req_o.ar.cache  = ar_out.cache;
        axi_req_o.ar.prot   = ar_out.prot;
        axi_req_o.ar.qos    = ar_out.qos;
        axi_req_o.ar.region = ar_out.region;
        axi_req_o.ar.user   = ar_out.user;
        axi_req_o.ar_valid  = ar_out_valid;
        axi_req_o.r_ready   = r_buf_ready;
    end

    assign aw_hs     = s_axi_awvalid & s_axi_awready;
    assign b_hs      = s_axi_bvalid & s_axi_bready & (wr_cnt_q != '0);
    assign ar_hs     = s_axi_arvalid & s_axi_arready;
    assign r_last_hs = s_axi_rvalid & s_axi_rready & s_axi_rlast & (rd_cnt_q != '0);
    assign atop_rd   = ATOP_EN & aw_hs & s_axi_awatop[5];

    // Next outstanding counts; completions seen at zero are dropped, and an
    // AR plus an atomic read in one cycle is clamped at the read limit.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (aw_hs && !b_hs)      wr_cnt_d = wr_cnt_q + WR_CW'(1);
        else if (b_hs && !aw_hs) wr_cnt_d = wr_cnt_q - WR_CW'(1);
        rd_sum   = {1'b0, rd_cnt_q} + RD_SW'(ar_hs) + RD_SW'(atop_rd) - RD_SW'(r_last_hs);
        rd_cnt_d = (rd_sum > {1'b0, RD_MAX}) ? RD_MAX : rd_sum[RD_CW-1:0];
    end

    // Outstanding counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_outst_o = wr_cnt_q;
    assign rd_outst_o = rd_cnt_q;
    assign idle_o     = rst_i | (aw_empty & w_empty & b_empty & ar_empty & r_empty &
                                 (wr_cnt_q == '0) & (rd_cnt_q == '0));
endmodule

// File: tb/tb_axi_slave_connector_cut.sv
// Directed bench for axi_slave_connector_cut: one fully cut instance with
// ATOP enabled and a read limit of 2, one with AR/R as wires.
module tb_axi_slave_connector_cut;
    import axi_slave_connector_cut_pkg::*;

    logic clk, rst;
    logic [3:0]  awid;   logic [63:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
    logic [1:0]  awburst; logic awlock; logic [3:0] awcache; logic [2:0] awprot;
    logic [3:0]  awqos;  logic [3:0] awregion; logic [0:0] awuser; logic [5:0] awatop;
    logic        awvalid;
    logic [63:0] wdata;  logic [7:0] wstrb; logic wlast; logic [0:0] wuser; logic wvalid;
    logic        bready;
    logic [3:0]  arid;   logic [63:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
    logic [1:0]  arburst; logic arlock; logic [3:0] arcache; logic [2:0] arprot;
    logic [3:0]  arqos;  logic [3:0] arregion; logic [0:0] aruser; logic arvalid;
    logic        rready;
    axi_rsp_t    rsp;

    logic a_awready, a_wready, a_bvalid, a_arready, a_rvalid, a_rlast, a_idle;
    logic [3:0] a_bid, a_rid; logic [1:0] a_bresp, a_rresp; logic [0:0] a_buser, a_ruser;
    logic [63:0] a_rdata; axi_req_t a_req; logic [3:0] a_wr; logic [1:0] a_rd;

    logic x_awready, x_wready, x_bvalid, x_arready, x_rvalid, x_rlast, x_idle;
    logic [3:0] x_bid, x_rid; logic [1:0] x_bresp, x_rresp; logic [0:0] x_buser, x_ruser;
    logic [63:0] x_rdata; axi_req_t x_req; logic [3:0] x_wr; logic [3:0] x_rd;

    int checks = 0;
    int errors = 0;

    axi_slave_connector_cut #(.ATOP_EN(1'b1), .MAX_RD_OUTST(2)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
        .s_axi_awprot(awprot), .s_axi_awqos(awqos), .s_axi_awregion(awregion),
        .s_axi_awuser(awuser), .s_axi_awatop(awatop), .s_axi_awvalid(awvalid),
        .s_axi_awready(a_awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wuser(wuser),
        .s_axi_wvalid(wvalid), .s_axi_wready(a_wready),
        .s_axi_bid(a_bid), .s_axi_bresp(a_bresp), .s_axi_buser(a_buser),
        .s_axi_bvalid(a_bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
        .s_axi_arprot(arprot), .s_axi_arqos(arqos), .s_axi_arregion(arregion),
        .s_axi_aruser(aruser), .s_axi_arvalid(arvalid), .s_axi_arready(a_arready),
        .s_axi_rid(a_rid), .s_axi_rdata(a_rdata), .s_axi_rresp(a_rresp), .s_axi_rlast(a_rlast),
        .s_axi_ruser(a_ruser), .s_axi_rvalid(a_rvalid), .s_axi_rready(rready),
        .axi_req_o(a_req), .axi_resp_i(rsp),
        .wr_outst_o(a_wr), .rd_outst_o(a_rd), .idle_o(a_idle));

    axi_slave_connector_cut #(.CUT_AR(1'b0), .CUT_R(1'b0)) dut_x (
        .clk_i(clk), .rst_i(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
        .s_axi_awprot(awprot), .s_axi_awqos(awqos), .s_axi_awregion(awregion),
        .s_axi_awuser(awuser), .s_axi_awatop(awatop), .s_axi_awvalid(awvalid),
        .s_axi_awready(x_awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wuser(wuser),
        .s_axi_wvalid(wvalid), .s_axi_wready(x_wready),
        .s_axi_bid(x_bid), .s_axi_bresp(x_bresp), .s_axi_buser(x_buser),
        .s_axi_bvalid(x_bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
        .s_axi_arprot(arprot), .s_axi_arqos(arqos), .s_axi_arregion(arregion),
        .s_axi_aruser(aruser), .s_axi_arvalid(arvalid), .s_axi_arready(x_arready),
        .s_axi_rid(x_rid), .s_axi_rdata(x_rdata), .s_axi_rresp(x_rresp), .s_axi_rlast(x_rlast),
        .s_axi_ruser(x_ruser), .s_axi_rvalid(x_rvalid), .s_axi_rready(rready),
        .axi_req_o(x_req), .axi_resp_i(rsp),
        .wr_outst_o(x_wr), .rd_outst_o(x_rd), .idle_o(x_idle));

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    initial begin
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'd1; awlock = 1'b0;
        awcache = '0; awprot = '0; awqos = '0; awregion = '0; awuser = '0; awatop = '0;
        awvalid = 1'b0;
        wdata = '0; wstrb = 8'hff; wlast = 1'b0; wuser = '0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'd1; arlock = 1'b0;
        arcache = '0; arprot = '0; arqos = '0; arregion = '0; aruser = '0; arvalid = 1'b0;
        rready = 1'b0;
        rsp = '0;

        // Reset state
        cyc(); cyc();
        #1;
        chk("rst_awready", a_awready, 0);
        chk("rst_idle", a_idle, 1);
        chk("rst_aw_valid", a_req.aw_valid, 0);
        rst = 1'b0;
        #1;
        chk("rel_awready", a_awready, 1);
        chk("rel_wr_outst", a_wr, 0);

        // Single AW through the cut, then its B
        awvalid = 1'b1; awid = 4'd3; awaddr = 64'h1000; awlen = 8'd0;
        #1;
        chk("aw_pre_edge_valid", a_req.aw_valid, 0);
        cyc();
        awvalid = 1'b0;
        #1;
        chk("aw_out_valid", a_req.aw_valid, 1);
        chk("aw_out_id", a_req.aw.id, 3);
        chk("aw_out_addr", a_req.aw.addr, 64'h1000);
        chk("aw_wr_outst", a_wr, 1);
        rsp.aw_ready = 1'b1;
        cyc();
        #1;
        chk("aw_drained", a_req.aw_valid, 0);
        rsp.b_valid = 1'b1; rsp.b.id = 4'd3; rsp.b.resp = 2'd0;
        cyc();
        rsp.b_valid = 1'b0;
        #1;
        chk("b_valid", a_bvalid, 1);
        chk("b_id", a_bid, 3);
        chk("b_resp", a_bresp, 0);
        chk("b_wr_outst_held", a_wr, 1);
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        #1;
        chk("b_wr_outst_done", a_wr, 0);
        chk("b_valid_gone", a_bvalid, 0);
        chk("b_idle", a_idle, 1);

        // AW and B handshakes in the same cycle
        awvalid = 1'b1; awid = 4'd5;
        cyc();
        awvalid = 1'b0;
        rsp.b_valid = 1'b1; rsp.b.id = 4'd5;
        cyc();
        rsp.b_valid = 1'b0;
        awvalid = 1'b1; bready = 1'b1;
        #1;
        chk("sim_bvalid", a_bvalid, 1);
        chk("sim_awready", a_awready, 1);
        cyc();
        awvalid = 1'b0; bready = 1'b0;
        #1;
        chk("sim_wr_outst", a_wr, 1);
        rsp.b_valid = 1'b1;
        cyc();
        rsp.b_valid = 1'b0; bready = 1'b1;
        cyc();
        bready = 1'b0;
        #1;
        chk("sim_wr_outst_clear", a_wr, 0);

        // 16-beat W burst at full rate
        rsp.w_ready = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = 64'(i); wlast = (i == 15);
            #1;
            if (i == 0) chk("w_first_latency", a_req.w_valid, 0);
            else begin
                chk("w_stream_valid", a_req.w_valid, 1);
                chk("w_stream_data", a_req.w.data, 64'(i - 1));
            end
            chk("w_stream_ready", a_wready, 1);
            cyc();
        end
        wvalid = 1'b0;
        #1;
        chk("w_last_data", a_req.w.data, 15);
        chk("w_last_flag", a_req.w.last, 1);
        cyc();

        // W backpressure: three cycles of w_ready low
        rsp.w_ready = 1'b0; wvalid = 1'b1; wdata = 64'd100; wlast = 1'b0;
        #1;
        chk("wbp_ready0", a_wready, 1);
        cyc();
        wdata = 64'd101;
        #1;
        chk("wbp_ready1", a_wready, 1);
        chk("wbp_out100", a_req.w.data, 100);
        cyc();
        wdata = 64'd102;
        #1;
        chk("wbp_full", a_wready, 0);
        cyc();
        #1;
        chk("wbp_hold100", a_req.w.data, 100);
        chk("wbp_still_full", a_wready, 0);
        rsp.w_ready = 1'b1;
        cyc();
        #1;
        chk("wbp_out101", a_req.w.data, 101);
        chk("wbp_reopen", a_wready, 1);
        cyc();
        wvalid = 1'b0;
        #1;
        chk("wbp_out102", a_req.w.data, 102);
        cyc();
        #1;
        chk("wbp_empty", a_req.w_valid, 0);
        chk("wbp_idle", a_idle, 1);

        // Read limit of 2
        rsp.ar_ready = 1'b1; arvalid = 1'b1; arid = 4'd1;
        #1;
        chk("ar1_ready", a_arready, 1);
        cyc();
        #1;
        chk("rd_seq_1", a_rd, 1);
        arid = 4'd2;
        cyc();
        arid = 4'd3;
        #1;
        chk("rd_seq_2", a_rd, 2);
        chk("ar_limited", a_arready, 0);
        cyc();
        #1;
        chk("rd_seq_3", a_rd, 2);
        rsp.r_valid = 1'b1; rsp.r.id = 4'd1; rsp.r.last = 1'b1; rsp.r.data = 64'haa;
        rready = 1'b1;
        cyc();
        rsp.r_valid = 1'b0;
        #1;
        chk("r_valid", a_rvalid, 1);
        chk("r_last", a_rlast, 1);
        chk("r_data", a_rdata, 64'haa);
        chk("ar_closed_at_dec", a_arready, 0);
        cyc();
        #1;
        chk("rd_seq_4", a_rd, 1);
        chk("ar_reopen", a_arready, 1);
        cyc();
        arvalid = 1'b0;
        #1;
        chk("rd_seq_5", a_rd, 2);
        rsp.r_valid = 1'b1;
        cyc(); cyc();
        rsp.r_valid = 1'b0;
        cyc();
        rready = 1'b0;
        #1;
        chk("rd_clear", a_rd, 0);

        // Atomic with read response counts on both sides
        awvalid = 1'b1; awid = 4'd7; awatop = 6'b100000;
        cyc();
        awvalid = 1'b0; awatop = 6'd0;
        #1;
        chk("atop_fwd", a_req.aw.atop, 6'h20);
        chk("atop_wr_outst", a_wr, 1);
        chk("atop_rd_outst", a_rd, 1);
        chk("atop_off_tied0", x_req.aw.atop, 0);

        // Reset with two R beats buffered
        rsp.r_valid = 1'b1; rsp.r.last = 1'b0;
        cyc(); cyc();
        rsp.r_valid = 1'b0;
        #1;
        chk("rbuf_valid", a_rvalid, 1);
        chk("rbuf_full", a_req.r_ready, 0);
        rst = 1'b1;
        cyc();
        #1;
        chk("rst2_rvalid", a_rvalid, 0);
        chk("rst2_rd_outst", a_rd, 0);
        chk("rst2_wr_outst", a_wr, 0);
        chk("rst2_idle", a_idle, 1);
        chk("rst2_awready", a_awready, 0);
        rst = 1'b0;
        #1;
        chk("rel2_awready", a_awready, 1);
        chk("rel2_idle", a_idle, 1);

        // AR/R as wires
        arvalid = 1'b1; arid = 4'd9; araddr = 64'h2000;
        #1;
        chk("wire_ar_valid", x_req.ar_valid, 1);
        chk("wire_ar_id", x_req.ar.id, 9);
        chk("wire_ar_addr", x_req.ar.addr, 64'h2000);
        chk("wire_arready", x_arready, 1);
        cyc();
        arvalid = 1'b0;
        #1;
        chk("wire_rd_outst1", x_rd, 1);
        chk("wire_ar_dropped", x_req.ar_valid, 0);
        rsp.r_valid = 1'b1; rsp.r.id = 4'd9; rsp.r.last = 1'b1; rsp.r.data = 64'h55;
        rready = 1'b1;
        #1;
        chk("wire_rvalid", x_rvalid, 1);
        chk("wire_rdata", x_rdata, 64'h55);
        chk("wire_rid", x_rid, 9);
        chk("cut_r_not_yet", a_rvalid, 0);
        cyc();
        rsp.r_valid = 1'b0; rready = 1'b0;
        #1;
        chk("wire_rd_outst0", x_rd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_slave_connector_cut.md
Name: axi_slave_connector_cut

Overview:
- Next-generation flat-AXI-slave to (axi_req_t, axi_rsp_t) connector.
- Adds a per-channel, parametrisable register cut: a 2-entry skid buffer with full throughput and independent AW/W/B/AR/R enables.
- Adds optional ATOP pass-through and outstanding-transaction limiting with read/write counters.
- Sits between an external AXI master port (IP-level, flat signals) and the pulp-struct fabric in front of the IO-PMP.

Parameters:
- DATA_WIDTH, 64, data bus width in bits
- ADDR_WIDTH, 64, address width
- STRB_WIDTH, DATA_WIDTH/8, strobe width
- ID_WIDTH, 4, AXI ID width
- USER_WIDTH, 1, width of all user fields (aw/w/b/ar/r)
- ATOP_EN, 0, 1 = drive aw.atop from s_axi_awatop; 0 = aw.atop tied to 0
- CUT_AW, CUT_W, CUT_B, CUT_AR, CUT_R, 1 each, 1 = skid buffer on that channel; 0 = combinational pass-through
- MAX_WR_OUTST, 8, max outstanding writes (AW accepted, B not yet returned); must be >= 1
- MAX_RD_OUTST, 8, max outstanding reads (AR accepted, last R not yet returned); must be >= 1
- axi_req_t, logic, request struct type
- axi_rsp_t, logic, response struct type

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  in  per AXI4 / param widths  write address fields
- s_axi_awatop  in  6  atomic op; ignored when ATOP_EN=0
- s_axi_awvalid  in  1
- s_axi_awready  out  1
- s_axi_w{data,strb,last,user}  in  DATA/STRB/1/USER  write data fields
- s_axi_wvalid  in  1
- s_axi_wready  out  1
- s_axi_b{id,resp,user}  out  ID/2/USER  write response fields
- s_axi_bvalid  out  1
- s_axi_bready  in  1
- s_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  in  as AW  read address fields
- s_axi_arvalid  in  1
- s_axi_arready  out  1
- s_axi_r{id,data,resp,last,user}  out  ID/DATA/2/1/USER  read data fields
- s_axi_rvalid  out  1
- s_axi_rready  in  1
- axi_req_o  out  axi_req_t  fabric request
- axi_resp_i  in  axi_rsp_t  fabric response
- wr_outst_o  out  $clog2(MAX_WR_OUTST+1)  current outstanding write count
- rd_outst_o  out  $clog2(MAX_RD_OUTST+1)  current outstanding read count
- idle_o  out  1  all buffers empty and both counters 0

Behaviour:
- Skid buffer (CUT_x=1), per channel:
  - 2 entries with an occupancy of 0/1/2.
  - Input ready = (occupancy < 2), registered; it is never a combinational function of output ready.
  - Output valid = (occupancy > 0); output payload is the oldest entry.
  - Latency 1 cycle: data accepted in cycle N appears at the output in N+1.
  - Sustains 1 beat/cycle with downstream ready held high.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - Push is ignored when full; pop is ignored when empty.
- CUT_x=0: channel is a pure wire, latency 0, as in the flat connector.
- Payload stability: once output valid is high it stays high with a stable payload until the handshake.
- Direction of cuts:
  - AW/W/AR cuts sit slave-side to axi_req_o.
  - B/R cuts sit axi_resp_i to slave-side.
- Write outstanding counter:
  - +1 on the slave-side AW handshake (s_axi_awvalid & s_axi_awready).
  - −1 on the slave-side B handshake.
  - Both in the same cycle: unchanged.
- Read outstanding counter:
  - +1 on the AR handshake.
  - −1 on an R handshake with rlast=1.
  - Both in the same cycle: unchanged.
- Limiting:
  - When wr_outst_o == MAX_WR_OUTST, s_axi_awready is forced 0 and no AW is pushed.
  - Same for AR with MAX_RD_OUTST.
  - The W channel is not limited.
  - A decrement in the same cycle does not re-open ready; ready re-opens next cycle. This keeps ready registered.
- Counter bounds: counters never exceed MAX and never underflow; a B or R-last arriving with count 0 is a protocol error and the counter stays 0.
- ATOP: when ATOP_EN=1, an ATOP write with a read response (atop[5]=1) also increments the read counter on AW handshake.
- Reset (rst_i=1 at a clk_i edge):
  - All occupancies → 0; counters → 0.
  - All output valids (axi_req_o.*_valid, s_axi_bvalid, s_axi_rvalid) 0 from the next cycle.
  - All slave-side readies 0 while rst_i=1; idle_o=1.
  - Reset mid-burst discards buffered beats without completing handshakes.
- After reset release: readies of empty cut channels go to 1 on the first cycle with rst_i=0.
- Unused struct fields are driven 0.

Test Plan:
- All CUT=1, single AW(id=3, addr=0x1000, len=0) → axi_req_o.aw_valid rises 1 cycle after the handshake with identical fields; wr_outst_o=1 until B(id=3, OKAY) is handshaken on the slave side, then 0; idle_o=1.
- W burst of 16 beats, axi_resp_i.w_ready=1 constantly → 16 beats out in 16 consecutive cycles, first beat 1 cycle late; then drop w_ready for 3 cycles → buffer fills to 2, s_axi_wready=0 after the 2nd held beat, no beat lost or reordered.
- MAX_RD_OUTST=2: issue 3 ARs back-to-back with no R returned → 2 accepted, s_axi_arready=0; return R(last=1) → arready=1 one cycle later, 3rd AR accepted; rd_outst_o sequence 1,2,2,1,2.
- Simultaneous AW handshake and B handshake with wr_outst_o=1 → stays 1.
- CUT_AR=0, CUT_R=0 → AR/R are combinational (0-cycle latency), counters still tracked.
- ATOP_EN=1, AW with atop=6'b100000 → aw.atop forwarded, both wr_outst_o and rd_outst_o increment.
- Assert rst_i with 2 beats buffered in R → s_axi_rvalid=0 next cycle, rd_outst_o=0, idle_o=1.
